uov_inst_loader: RTL and testbench

//  Instruction-load front end of the uov core, active in SEND_INSTRUCTION state.

---
 rtl/uov_pkg.sv | 30 +++
 rtl/uov_inst_loader.sv | 109 ++++++++++
 tb/tb_uov_inst_loader.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/uov_pkg.sv
// Shared definitions for the uov core: input-state codes, cmd_in field layout
// helpers and the instruction-loader state encoding.
package uov_pkg;

  localparam int unsigned SEND_INSTRUCTION = 3;

  localparam int unsigned DEF_INST_DEPTH    = 1024;
  localparam int unsigned DEF_INST_LEN      = 32;
  localparam int unsigned DEF_STABLE_CYCLES = 2;

  // cmd_in layout: {strobe, addr[ADDR_W-1:0], data[INST_LEN-1:0]}
  localparam int unsigned CMD_DATA_LSB = 0;

  function automatic int unsigned cmd_addr_lsb(input int unsigned inst_len);
    return inst_len;
  endfunction

  function automatic int unsigned cmd_strobe_bit(input int unsigned inst_len,
                                                 input int unsigned addr_w);
    return inst_len + addr_w;
  endfunction

  typedef enum logic [1:0] {
    LD_ARM     = 2'd0,
    LD_FILTER  = 2'd1,
    LD_WRITE   = 2'd2,
    LD_RELEASE = 2'd3
  } ld_state_e;

endpackage

// File: rtl/uov_inst_loader.sv
// Instruction-load front end: debounces host write strobes and turns each
// accepted command into one instruction-memory write, with count/checksum.
module uov_inst_loader
  import uov_pkg::*;
#(
  parameter  int unsigned INST_DEPTH    = DEF_INST_DEPTH,
  parameter  int unsigned INST_LEN      = DEF_INST_LEN,
  parameter  int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  localparam int unsigned ADDR_W        = $clog2(INST_DEPTH),
  localparam int unsigned CMD_W         = INST_LEN + ADDR_W + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [CMD_W-1:0]    cmd_in,
  output logic                inst_wr_en,
  output logic [ADDR_W-1:0]   inst_wr_addr,
  output logic [INST_LEN-1:0] inst_wr_data,
  output logic [ADDR_W:0]     word_count,
  output logic [INST_LEN-1:0] checksum,
  output logic                load_done
);

  localparam int unsigned CNT_W      = ADDR_W + 1;
  localparam int unsigned FLT_W      = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam int unsigned ADDR_LSB   = cmd_addr_lsb(INST_LEN);
  localparam int unsigned STROBE_BIT = cmd_strobe_bit(INST_LEN, ADDR_W);

  logic                strobe;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [INST_LEN-1:0] cmd_data;

  assign strobe   = cmd_in[STROBE_BIT];
  assign cmd_addr = cmd_in[ADDR_LSB +: ADDR_W];
  assign cmd_data = cmd_in[CMD_DATA_LSB +: INST_LEN];

  ld_state_e        state;
  logic             armed;
  logic [FLT_W-1:0] flt_cnt;

  // Loader FSM; ARM with armed=1 is the idle-low state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= LD_ARM;
      armed        <= 1'b0;
      flt_cnt      <= '0;
      inst_wr_en   <= 1'b0;
      inst_wr_addr <= '0;
      inst_wr_data <= '0;
      word_count   <= '0;
      checksum     <= '0;
      load_done    <= 1'b0;
    end else begin
      inst_wr_en <= 1'b0;
      load_done  <= load_done | (word_count == CNT_W'(INST_DEPTH));

      // A write that has been latched always completes, even if enable drops.
      if (state == LD_WRITE) begin
        inst_wr_en <= 1'b1;
        checksum   <= checksum ^ inst_wr_data;
        if (word_count < CNT_W'(INST_DEPTH)) begin
          word_count <= word_count + CNT_W'(1);
        end
      end

      if (!enable) begin
        state   <= LD_ARM;
        armed   <= 1'b0;
        flt_cnt <= '0;
      end else begin
        case (state)
          LD_ARM: begin
            if (!armed) begin
              if (!strobe) armed <= 1'b1;
            end else if (strobe) begin
              state   <= LD_FILTER;
              flt_cnt <= FLT_W'(1);
            end
          end
          LD_FILTER: begin
            if (!strobe) begin
              state <= LD_ARM;
            end else if (flt_cnt == FLT_W'(STABLE_CYCLES)) begin
              inst_wr_addr <= cmd_addr;
              inst_wr_data <= cmd_data;
              state        <= LD_WRITE;
            end else begin
              flt_cnt <= flt_cnt + FLT_W'(1);
            end
          end
          LD_WRITE: begin
            state <= LD_RELEASE;
          end
          LD_RELEASE: begin
            if (!strobe) begin
              state <= LD_ARM;
              armed <= 1'b1;
            end
          end
          default: begin
            state <= LD_ARM;
            armed <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uov_inst_loader.sv
// Directed bench for uov_inst_loader: strobe arming, filtering, single-write
// per strobe, count/checksum/load_done and asynchronous reset.
module tb_uov_inst_loader;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DLEN   = 32;
  localparam int unsigned CMD_W  = DLEN + ADDR_W + 1;
  localparam int unsigned SB     = CMD_W - 1;

  logic              clk;
  logic              rst_n;
  logic              enable;
  logic [CMD_W-1:0]  cmd_in;
  logic              inst_wr_en;
  logic [ADDR_W-1:0] inst_wr_addr;
  logic [DLEN-1:0]   inst_wr_data;
  logic [ADDR_W:0]   word_count;
  logic [DLEN-1:0]   checksum;
  logic              load_done;

  int checks = 0;
  int errors = 0;

  logic [ADDR_W-1:0] last_addr;
  logic [DLEN-1:0]   last_data;

  uov_inst_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .cmd_in       (cmd_in),
    .inst_wr_en   (inst_wr_en),
    .inst_wr_addr (inst_wr_addr),
    .inst_wr_data (inst_wr_data),
    .word_count   (word_count),
    .checksum     (checksum),
    .load_done    (load_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Watch wr_en for n negedges; report pulse count and first-pulse position.
  task automatic watch(input int n, output int pulses, output int lat);
    pulses = 0;
    lat    = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (inst_wr_en === 1'b1) begin
        pulses++;
        if (lat == 0) lat = i;
        last_addr = inst_wr_addr;
        last_data = inst_wr_data;
      end
    end
  endtask

  task automatic host_write(input logic [ADDR_W-1:0] a, input logic [DLEN-1:0] d,
                            input int hold, output int pulses, output int lat);
    @(negedge clk);
    cmd_in = {1'b0, a, d};
    @(negedge clk);
    cmd_in[SB] = 1'b1;
    watch(hold, pulses, lat);
    cmd_in[SB] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int p;
    int l;
    int bad;

    rst_n  = 1'b0;
    enable = 1'b0;
    cmd_in = {1'b1, 10'd5, 32'hDEADBEEF};
    last_addr = '0;
    last_data = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_wr_en", inst_wr_en, 0);
    chk("rst_wr_addr", inst_wr_addr, 0);
    chk("rst_wr_data", inst_wr_data, 0);
    chk("rst_count", word_count, 0);
    chk("rst_checksum", checksum, 0);
    chk("rst_done", load_done, 0);

    // 1: strobe already high at enable must not write
    rst_n  = 1'b1;
    enable = 1'b1;
    watch(8, p, l);
    chk("prehigh_no_write", p, 0);
    chk("prehigh_count", word_count, 0);

    // 2: single write, latency and payload
    host_write(10'd5, 32'hDEADBEEF, 6, p, l);
    chk("w1_pulses", p, 1);
    chk("w1_latency", l, 4);
    chk("w1_addr", last_addr, 5);
    chk("w1_data", last_data, 32'hDEADBEEF);
    chk("w1_count", word_count, 1);
    chk("w1_checksum", checksum, 32'hDEADBEEF);

    // 3: one-cycle glitch
    @(negedge clk);
    cmd_in = {1'b0, 10'd9, 32'h0BADF00D};
    @(negedge clk);
    cmd_in[SB] = 1'b1;
    @(negedge clk);
    cmd_in[SB] = 1'b0;
    watch(6, p, l);
    chk("glitch_no_write", p, 0);
    chk("glitch_count", word_count, 1);

    // 4: strobe held for 20 cycles
    host_write(10'd7, 32'h12345678, 20, p, l);
    chk("hold_pulses", p, 1);
    chk("hold_addr", last_addr, 7);
    chk("hold_count", word_count, 2);
    chk("hold_checksum", checksum, 32'hCC99E897);

    // 6a: drop enable mid-FILTER, then re-enable with strobe still high
    @(negedge clk);
    cmd_in = {1'b0, 10'd3, 32'hAAAA5555};
    @(negedge clk);
    cmd_in[SB] = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    watch(6, p, l);
    chk("abort_no_write", p, 0);
    enable = 1'b1;
    watch(6, p, l);
    chk("reenable_high_no_write", p, 0);
    chk("abort_count", word_count, 2);
    chk("abort_checksum", checksum, 32'hCC99E897);
    cmd_in[SB] = 1'b0;
    @(negedge clk);

    // 5: fresh reset, then fill all 1024 words with data = addr
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 1023; i++) begin
      host_write(ADDR_W'(i), DLEN'(i), 5, p, l);
      if (p != 1 || last_addr != ADDR_W'(i) || last_data != DLEN'(i)) bad++;
    end
    chk("fill_1023_count", word_count, 1023);
    chk("fill_1023_done", load_done, 0);
    host_write(10'd1023, 32'd1023, 5, p, l);
    if (p != 1 || last_addr != 10'd1023) bad++;
    chk("fill_bad_writes", bad, 0);
    chk("fill_count", word_count, 1024);
    chk("fill_checksum", checksum, 0);
    chk("fill_done", load_done, 1);

    // Write after load_done: performed, count saturated
    host_write(10'd2, 32'hF0F0F0F0, 6, p, l);
    chk("post_done_pulses", p, 1);
    chk("post_done_count", word_count, 1024);
    chk("post_done_checksum", checksum, 32'hF0F0F0F0);
    chk("post_done_sticky", load_done, 1);

    // 6b: asynchronous reset while in WRITE
    @(negedge clk);
    cmd_in = {1'b0, 10'd300, 32'h13579BDF};
    @(negedge clk);
    cmd_in[SB] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_latched_addr", inst_wr_addr, 300);
    chk("pre_rst_wr_en", inst_wr_en, 0);
    rst_n = 1'b0;
    #1;
    chk("midwr_rst_wr_en", inst_wr_en, 0);
    chk("midwr_rst_addr", inst_wr_addr, 0);
    chk("midwr_rst_data", inst_wr_data, 0);
    chk("midwr_rst_count", word_count, 0);
    chk("midwr_rst_checksum", checksum, 0);
    chk("midwr_rst_done", load_done, 0);
    watch(4, p, l);
    chk("in_rst_no_write", p, 0);
    rst_n = 1'b1;
    watch(6, p, l);
    chk("after_rst_held_strobe_no_write", p, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
